// File: rtl/namuru_time_base.sv
// Namuru time base: sample-rate divider, TIC / ACCUM_INT epoch generation,
// sticky status and per-channel new-data flags with clear-on-read, and irq.
module namuru_time_base #(
  parameter int unsigned NCH        = 12,
  parameter int unsigned SAMPLE_DIV = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              rstn,
  input  logic [23:0]       prog_tic,
  input  logic [23:0]       prog_accum_int,
  input  logic [NCH-1:0]    ch_dump,
  input  logic              status_read,
  input  logic              new_data_read,
  output logic              sample_enable,
  output logic              pre_tic_enable,
  output logic              tic_enable,
  output logic              accum_enable,
  output logic [23:0]       tic_count,
  output logic [23:0]       accum_count,
  output logic [1:0]        status,
  output logic [NCH-1:0]    new_data,
  output logic              irq
);

  localparam int unsigned CNT_W  = 24;
  localparam int unsigned SDIV_W = $clog2(SAMPLE_DIV);
  localparam logic [SDIV_W-1:0] SDIV_LAST = SDIV_W'(SAMPLE_DIV - 1);

  logic [SDIV_W-1:0] sdiv;
  logic              tic_pending;
  logic [NCH-1:0]    dump_prev;
  logic              sample_cycle_c;
  logic [NCH-1:0]    nd_clear_c;

  assign sample_cycle_c = (sdiv == SDIV_LAST);

  // A read only clears channels with no dump this cycle or the previous one.
  assign nd_clear_c = {NCH{new_data_read}} & ~(ch_dump | dump_prev);

  // Sample divider and sample strobe.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sdiv          <= '0;
      sample_enable <= 1'b0;
    end else if (!rstn) begin
      sdiv          <= '0;
      sample_enable <= 1'b0;
    end else begin
      sdiv          <= sample_cycle_c ? '0 : sdiv + SDIV_W'(1);
      sample_enable <= sample_cycle_c;
    end
  end

  // TIC down-counter; reload on zero raises the early TIC pulse.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tic_count      <= '0;
      pre_tic_enable <= 1'b0;
    end else if (!rstn) begin
      tic_count      <= prog_tic;
      pre_tic_enable <= 1'b0;
    end else if (sample_enable) begin
      if (tic_count == '0) begin
        tic_count      <= prog_tic;
        pre_tic_enable <= 1'b1;
      end else begin
        tic_count      <= tic_count - CNT_W'(1);
        pre_tic_enable <= 1'b0;
      end
    end else begin
      pre_tic_enable <= 1'b0;
    end
  end

  // Delayed TIC: fires after the sample strobe following the early pulse.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      tic_pending <= 1'b0;
      tic_enable  <= 1'b0;
    end else if (!rstn) begin
      tic_pending <= 1'b0;
      tic_enable  <= 1'b0;
    end else begin
      tic_enable <= tic_pending && sample_enable;
      if (pre_tic_enable) begin
        tic_pending <= 1'b1;
      end else if (sample_enable) begin
        tic_pending <= 1'b0;
      end
    end
  end

  // ACCUM_INT down-counter; same scheme as TIC without the delayed copy.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      accum_count  <= '0;
      accum_enable <= 1'b0;
    end else if (!rstn) begin
      accum_count  <= prog_accum_int;
      accum_enable <= 1'b0;
    end else if (sample_enable) begin
      if (accum_count == '0) begin
        accum_count  <= prog_accum_int;
        accum_enable <= 1'b1;
      end else begin
        accum_count  <= accum_count - CNT_W'(1);
        accum_enable <= 1'b0;
      end
    end else begin
      accum_enable <= 1'b0;
    end
  end

  // Sticky status; a set coinciding with a read wins.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      status <= '0;
    end else if (!rstn) begin
      status <= '0;
    end else begin
      status[0] <= tic_enable   | (status[0] & ~status_read);
      status[1] <= accum_enable | (status[1] & ~status_read);
    end
  end

  // Sticky per-channel new-data flags and one-cycle dump history.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      new_data  <= '0;
      dump_prev <= '0;
    end else if (!rstn) begin
      new_data  <= '0;
      dump_prev <= '0;
    end else begin
      new_data  <= ch_dump | (new_data & ~nd_clear_c);
      dump_prev <= ch_dump;
    end
  end

  // Interrupt is the registered OR of status.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |status;
    end
  end

endmodule

// File: tb/tb_namuru_time_base.sv
// Directed bench for namuru_time_base (NCH=12, SAMPLE_DIV=4).
module tb_namuru_time_base;

  localparam int unsigned NCH = 12;

  logic            sys_clk;
  logic            sys_rst;
  logic            rstn;
  logic [23:0]     prog_tic;
  logic [23:0]     prog_accum_int;
  logic [NCH-1:0]  ch_dump;
  logic            status_read;
  logic            new_data_read;
  logic            sample_enable;
  logic            pre_tic_enable;
  logic            tic_enable;
  logic            accum_enable;
  logic [23:0]     tic_count;
  logic [23:0]     accum_count;
  logic [1:0]      status;
  logic [NCH-1:0]  new_data;
  logic            irq;

  namuru_time_base #(.NCH(NCH), .SAMPLE_DIV(4)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .rstn           (rstn),
    .prog_tic       (prog_tic),
    .prog_accum_int (prog_accum_int),
    .ch_dump        (ch_dump),
    .status_read    (status_read),
    .new_data_read  (new_data_read),
    .sample_enable  (sample_enable),
    .pre_tic_enable (pre_tic_enable),
    .tic_enable     (tic_enable),
    .accum_enable   (accum_enable),
    .tic_count      (tic_count),
    .accum_count    (accum_count),
    .status         (status),
    .new_data       (new_data),
    .irq            (irq)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          cyc;
    logic        se;
    logic        pre;
    logic        tic;
    logic        acc;
    logic [23:0] cnt;
    logic [1:0]  st;
    logic        irq;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  function automatic vec_t mk(int c, logic se, logic pre, logic tic, logic acc,
                              logic [23:0] cnt, logic [1:0] st, logic iq);
    vec_t v;
    v.cyc = c; v.se = se; v.pre = pre; v.tic = tic; v.acc = acc;
    v.cnt = cnt; v.st = st; v.irq = iq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return sample_enable;
      1:       return pre_tic_enable;
      2:       return tic_enable;
      default: return accum_enable;
    endcase
  endfunction

  // Step until the selected pulse is seen or the budget runs out (at = -1).
  task automatic wait_for(input int which, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (sig(which)) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int n_se, n_pre, n_tic, n_acc, at, r, n_idle;

    sys_rst        = 1'b1;
    rstn           = 1'b0;
    prog_tic       = 24'd9;
    prog_accum_int = 24'd2;
    ch_dump        = '0;
    status_read    = 1'b0;
    new_data_read  = 1'b0;

    // cyc, se, pre, tic, acc, tic_count, status, irq
    tbl.push_back(mk( 1, 0, 0, 0, 0, 24'd9, 2'd0, 0));
    tbl.push_back(mk( 3, 0, 0, 0, 0, 24'd9, 2'd0, 0));
    tbl.push_back(mk( 4, 1, 0, 0, 0, 24'd9, 2'd0, 0));
    tbl.push_back(mk( 5, 0, 0, 0, 0, 24'd8, 2'd0, 0));
    tbl.push_back(mk( 8, 1, 0, 0, 0, 24'd8, 2'd0, 0));
    tbl.push_back(mk(12, 1, 0, 0, 0, 24'd7, 2'd0, 0));
    tbl.push_back(mk(13, 0, 0, 0, 1, 24'd6, 2'd0, 0));
    tbl.push_back(mk(14, 0, 0, 0, 0, 24'd6, 2'd2, 0));
    tbl.push_back(mk(15, 0, 0, 0, 0, 24'd6, 2'd2, 1));
    tbl.push_back(mk(25, 0, 0, 0, 1, 24'd3, 2'd2, 1));
    tbl.push_back(mk(37, 0, 0, 0, 1, 24'd0, 2'd2, 1));
    tbl.push_back(mk(40, 1, 0, 0, 0, 24'd0, 2'd2, 1));
    tbl.push_back(mk(41, 0, 1, 0, 0, 24'd9, 2'd2, 1));
    tbl.push_back(mk(44, 1, 0, 0, 0, 24'd9, 2'd2, 1));
    tbl.push_back(mk(45, 0, 0, 1, 0, 24'd8, 2'd2, 1));
    tbl.push_back(mk(46, 0, 0, 0, 0, 24'd8, 2'd3, 1));
    tbl.push_back(mk(49, 0, 0, 0, 1, 24'd7, 2'd3, 1));
    tbl.push_back(mk(81, 0, 1, 0, 0, 24'd9, 2'd3, 1));
    tbl.push_back(mk(85, 0, 0, 1, 1, 24'd8, 2'd3, 1));

    // Reset state.
    #2;
    chk("rst_pulses", {28'd0, sample_enable, pre_tic_enable, tic_enable, accum_enable}, 32'd0);
    chk("rst_tic_count", {8'd0, tic_count}, 32'd0);
    chk("rst_flags", {17'd0, status, new_data, irq}, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    step();
    chk("idle_tic_count", {8'd0, tic_count}, 32'd9);

    // Main periodic run, table-driven; cycle 0 is the first cycle with rstn high.
    rstn = 1'b1;
    cyc  = 0;
    n_se = 0; n_pre = 0; n_tic = 0; n_acc = 0;
    for (int c = 1; c <= 85; c++) begin
      step();
      n_se  += int'(sample_enable);
      n_pre += int'(pre_tic_enable);
      n_tic += int'(tic_enable);
      n_acc += int'(accum_enable);
      foreach (tbl[k]) begin
        if (tbl[k].cyc == cyc) begin
          chk($sformatf("vec%0d_pulses", cyc),
              {28'd0, sample_enable, pre_tic_enable, tic_enable, accum_enable},
              {28'd0, tbl[k].se, tbl[k].pre, tbl[k].tic, tbl[k].acc});
          chk($sformatf("vec%0d_tic_count", cyc), {8'd0, tic_count}, {8'd0, tbl[k].cnt});
          chk($sformatf("vec%0d_status", cyc), {30'd0, status}, {30'd0, tbl[k].st});
          chk($sformatf("vec%0d_irq", cyc), {31'd0, irq}, {31'd0, tbl[k].irq});
        end
      end
    end
    chk("count_sample_enable", n_se, 21);
    chk("count_pre_tic", n_pre, 2);
    chk("count_tic", n_tic, 2);
    chk("count_accum", n_acc, 7);

    // Status read alone clears; irq drops one cycle later.
    run_to(86);
    status_read = 1'b1;
    step();
    status_read = 1'b0;
    chk("read_clears_status", {30'd0, status}, 32'd0);
    chk("irq_lags_status", {31'd0, irq}, 32'd1);
    step();
    chk("irq_cleared", {31'd0, irq}, 32'd0);

    // Status read coinciding with accum_enable: set wins.
    run_to(97);
    chk("accum_at_97", {31'd0, accum_enable}, 32'd1);
    status_read = 1'b1;
    step();
    status_read = 1'b0;
    chk("set_wins_over_read", {30'd0, status}, 32'd2);

    // prog_accum_int change mid-count only takes effect at the next reload.
    run_to(100);
    prog_accum_int = 24'd5;
    wait_for(3, 40, at);
    chk("accum_old_period", at, 109);
    wait_for(3, 40, at);
    chk("accum_new_period1", at, 133);
    wait_for(3, 40, at);
    chk("accum_new_period2", at, 157);

    // Dump then read five cycles later: bit clears.
    ch_dump = 12'h008;
    step();
    ch_dump = '0;
    chk("dump_sets_bit3", {20'd0, new_data}, 32'h008);
    repeat (4) step();
    new_data_read = 1'b1;
    step();
    new_data_read = 1'b0;
    chk("late_read_clears", {20'd0, new_data}, 32'h000);

    // Dump one cycle before the read: bit survives, later read clears it.
    ch_dump = 12'h008;
    step();
    ch_dump       = '0;
    new_data_read = 1'b1;
    step();
    new_data_read = 1'b0;
    chk("prev_dump_masks_read", {20'd0, new_data}, 32'h008);
    repeat (2) step();
    new_data_read = 1'b1;
    step();
    new_data_read = 1'b0;
    chk("second_read_clears", {20'd0, new_data}, 32'h000);

    // Dump in the same cycle as the read: bit3 kept, unmasked bit5 cleared.
    ch_dump = 12'h020;
    step();
    ch_dump = '0;
    repeat (2) step();
    ch_dump       = 12'h008;
    new_data_read = 1'b1;
    step();
    ch_dump       = '0;
    new_data_read = 1'b0;
    chk("same_cycle_dump_masks", {20'd0, new_data}, 32'h008);

    // Drop rstn mid-period: idle next cycle, counters track prog values.
    repeat (7) step();
    rstn     = 1'b0;
    prog_tic = 24'd6;
    step();
    chk("idle_pulses", {28'd0, sample_enable, pre_tic_enable, tic_enable, accum_enable}, 32'd0);
    chk("idle_tic_load", {8'd0, tic_count}, 32'd6);
    chk("idle_accum_load", {8'd0, accum_count}, 32'd5);
    chk("idle_status", {30'd0, status}, 32'd0);
    chk("idle_new_data", {20'd0, new_data}, 32'd0);
    n_idle = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n_idle += int'(sample_enable | pre_tic_enable | tic_enable | accum_enable);
    end
    chk("idle_no_pulses", n_idle, 0);
    chk("idle_irq", {31'd0, irq}, 32'd0);

    // Restart: full periods from the rising edge of rstn.
    rstn = 1'b1;
    r    = cyc;
    wait_for(0, 20, at);
    chk("restart_first_sample", at - r, 4);
    wait_for(3, 40, at);
    chk("restart_first_accum", at - r, 25);
    wait_for(1, 40, at);
    chk("restart_first_pre_tic", at - r, 29);
    chk("restart_tic_count", {8'd0, tic_count}, 32'd6);

    // Asynchronous reset between edges clears everything immediately.
    #3;
    sys_rst = 1'b1;
    #1;
    chk("async_rst_pulses", {28'd0, sample_enable, pre_tic_enable, tic_enable, accum_enable}, 32'd0);
    chk("async_rst_counts", {8'd0, tic_count} | {8'd0, accum_count}, 32'd0);
    chk("async_rst_flags", {17'd0, status, new_data, irq}, 32'd0);
    #2;
    sys_rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
